// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin arbiter that folds several writeback sources
// onto the single write port of the register file through a one-entry stage.
// Optional build macro RF_WB_DROP_R0_EN: writes to index 0 are accepted and
// staged, but never strobed into the file and never reported as pending.
module rf_write_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned AW   = 5,
  parameter int unsigned DW   = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  input  logic                 rf_stall,
  output logic                 rf_load_enable,
  output logic [AW-1:0]        rf_rc,
  output logic [DW-1:0]        rf_ry,
  output logic [1:0]           grant_id,
  output logic [2**AW-1:0]     pend_mask
);

  localparam int unsigned IW    = 2;
  localparam int unsigned NPEND = 2**AW;

  logic            out_valid;
  logic [AW-1:0]   out_addr;
  logic [DW-1:0]   out_data;
  logic [IW-1:0]   rr_ptr;

  logic [2*NREQ-1:0] dbl_valid;
  logic [NREQ-1:0]   rot_valid;
  logic              win_found;
  int unsigned       win_offs;
  int unsigned       win_sum;
  logic [IW-1:0]     win_idx;
  logic [IW-1:0]     rr_next;
  logic [AW-1:0]     win_addr;
  logic [DW-1:0]     win_data;
  logic              can_take;
  logic              xfer;
  logic              wr_live;

  // Round-robin search: rotate valids so bit 0 is the pointer, take first set bit.
  always_comb begin
    dbl_valid = {req_valid, req_valid} >> rr_ptr;
    rot_valid = dbl_valid[NREQ-1:0];
    win_found = 1'b0;
    win_offs  = 0;
    for (int k = 0; k < NREQ; k++) begin
      if (!win_found && rot_valid[k]) begin
        win_found = 1'b1;
        win_offs  = 32'(k);
      end
    end
    win_sum = 32'(rr_ptr) + win_offs;
    if (win_sum >= NREQ) begin
      win_sum = win_sum - NREQ;
    end
    win_idx = IW'(win_sum);
    rr_next = (win_sum == NREQ - 1) ? '0 : IW'(win_idx + 2'd1);
  end

  // Select the winner's payload.
  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (32'(win_idx) == 32'(i)) begin
        win_addr = req_addr[i*AW +: AW];
        win_data = req_data[i*DW +: DW];
      end
    end
  end

  // Handshake: the stage can take a new write if empty or draining this cycle.
  always_comb begin
    can_take  = !out_valid || !rf_stall;
    xfer      = reset_n && win_found && can_take;
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = xfer && (32'(win_idx) == 32'(i));
    end
  end

  // Output stage, grant record and round-robin pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      rr_ptr    <= '0;
      grant_id  <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_addr  <= win_addr;
      out_data  <= win_data;
      rr_ptr    <= rr_next;
      grant_id  <= win_idx;
    end else if (!rf_stall) begin
      out_valid <= 1'b0;
    end
  end

  // Write port and pending-index decode from the staged write.
  always_comb begin
`ifdef RF_WB_DROP_R0_EN
    wr_live = out_valid && (out_addr != '0);
`else
    wr_live = out_valid;
`endif
    rf_load_enable = wr_live && !rf_stall;
    rf_rc          = out_addr;
    rf_ry          = out_data;
    pend_mask      = '0;
    if (wr_live) begin
      pend_mask = NPEND'(1) << out_addr;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: a high-level model predicts grants
// and the order of register-file writes; a monitor checks the write port.
module tb_rf_write_arbiter;

  localparam int unsigned NREQ = 3;
  localparam int unsigned AW   = 5;
  localparam int unsigned DW   = 32;
`ifdef RF_WB_DROP_R0_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic                clk;
  logic                reset_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*AW-1:0]  req_addr;
  logic [NREQ*DW-1:0]  req_data;
  logic                stall_tb;
  logic                rf_load_enable;
  logic [AW-1:0]       rf_rc;
  logic [DW-1:0]       rf_ry;
  logic [1:0]          grant_id;
  logic [2**AW-1:0]    pend_mask;

  rf_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_data       (req_data),
    .rf_stall       (stall_tb),
    .rf_load_enable (rf_load_enable),
    .rf_rc          (rf_rc),
    .rf_ry          (rf_ry),
    .grant_id       (grant_id),
    .pend_mask      (pend_mask)
  );

  // Requester-side state: each source holds one request until it is taken.
  bit            vld [NREQ];
  logic [AW-1:0] cad [NREQ];
  logic [DW-1:0] cdt [NREQ];

  // Reference model of the stage, pointer and expected write order.
  bit            m_ov;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int            m_ptr;
  int            m_grant;
  wr_t           expq[$];

  int ncmp;
  int nfail;
  bit in_rst;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]           = vld[i];
      req_addr[i*AW +: AW]   = cad[i];
      req_data[i*DW +: DW]   = cdt[i];
    end
  endtask

  task automatic new_req(input int i);
    vld[i] = 1'b1;
    cad[i] = ($urandom_range(0, 5) == 0) ? '0 : AW'($urandom_range(0, 31));
    cdt[i] = $urandom;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NREQ; i++) vld[i] = 1'b0;
  endtask

  // One clock: drive at negedge, check ready, update model at posedge.
  task automatic step(input bit rnd, input bit stl);
    int            w;
    bit            ct;
    logic [NREQ-1:0] er;
    wr_t           e;
    @(negedge clk);
    if (rnd) begin
      for (int i = 0; i < NREQ; i++)
        if (!vld[i] && $urandom_range(0, 1) == 1) new_req(i);
    end
    stall_tb = stl;
    drive();
    w = -1;
    for (int k = 0; k < NREQ; k++) begin
      int c;
      c = (m_ptr + k) % NREQ;
      if (w < 0 && vld[c]) w = c;
    end
    ct = !m_ov || !stl;
    er = '0;
    if (w >= 0 && ct) er[w] = 1'b1;
    #1;
    chk("req_ready", 64'(req_ready), 64'(er));
    @(posedge clk);
    if (w >= 0 && ct) begin
      m_ov    = 1'b1;
      m_addr  = cad[w];
      m_data  = cdt[w];
      m_grant = w;
      m_ptr   = (w + 1) % NREQ;
      if (!(DROP && cad[w] == '0)) begin
        e.a = cad[w];
        e.d = cdt[w];
        expq.push_back(e);
      end
      vld[w] = 1'b0;
    end else if (!stl) begin
      m_ov = 1'b0;
    end
  endtask

  // Monitor: compare the write port against the model every cycle.
  initial begin
    bit  live;
    bit  iss;
    wr_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!in_rst) begin
        live = m_ov && !(DROP && m_addr == '0);
        iss  = live && !stall_tb;
        chk("load_enable", 64'(rf_load_enable), 64'(iss));
        chk("pend_mask", 64'(pend_mask), live ? (64'(1) << m_addr) : 64'(0));
        chk("grant_id", 64'(grant_id), 64'(m_grant));
        if (iss) begin
          if (expq.size() == 0) begin
            ncmp++;
            nfail++;
            $display("FAIL sb_empty: write issued with no expected entry at %0t", $time);
          end else begin
            e = expq.pop_front();
            chk("rf_rc", 64'(rf_rc), 64'(e.a));
            chk("rf_ry", 64'(rf_ry), 64'(e.d));
          end
        end
      end
    end
  end

  initial begin
    int s;
    ncmp = 0; nfail = 0;
    in_rst = 1'b1;
    reset_n = 1'b0;
    stall_tb = 1'b0;
    m_ov = 1'b0; m_addr = '0; m_data = '0; m_ptr = 0; m_grant = 0;
    for (int i = 0; i < NREQ; i++) begin
      vld[i] = 1'b0; cad[i] = '0; cdt[i] = '0;
    end
    vld[0] = 1'b1; cad[0] = AW'(4); cdt[0] = 32'h1;
    drive();
    #3;
    chk("rst_ready", 64'(req_ready), 64'(0));
    chk("rst_load_en", 64'(rf_load_enable), 64'(0));
    chk("rst_rc", 64'(rf_rc), 64'(0));
    chk("rst_ry", 64'(rf_ry), 64'(0));
    chk("rst_grant", 64'(grant_id), 64'(0));
    chk("rst_pend", 64'(pend_mask), 64'(0));
    clear_reqs();
    drive();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    in_rst  = 1'b0;

    // Single write of r5.
    vld[0] = 1'b1; cad[0] = AW'(5); cdt[0] = 32'hDEADBEEF;
    step(0, 0);
    #1;
    chk("single_rc", 64'(rf_rc), 64'(5));
    chk("single_ry", 64'(rf_ry), 64'(32'hDEADBEEF));
    chk("single_pend", 64'(pend_mask), 64'(32'h20));
    step(0, 0);

    // Round-robin with every source continuously valid.
    s = m_ptr;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NREQ; i++) if (!vld[i]) new_req(i);
      step(0, 0);
      #1;
      chk("rr_grant", 64'(grant_id), 64'((s + r) % NREQ));
    end
    clear_reqs();
    step(0, 0);
    step(0, 0);

    // Stall holding r7 while req1 waits.
    vld[0] = 1'b1; cad[0] = AW'(7); cdt[0] = 32'h1234;
    step(0, 0);
    vld[1] = 1'b1; cad[1] = AW'(8); cdt[1] = 32'h5555;
    repeat (3) begin
      step(0, 1);
      #1;
      chk("stall_hold_rc", 64'(rf_rc), 64'(7));
      chk("stall_hold_ry", 64'(rf_ry), 64'(32'h1234));
    end
    step(0, 0);
    #1;
    chk("stall_release_grant", 64'(grant_id), 64'(1));
    chk("stall_release_rc", 64'(rf_rc), 64'(8));
    step(0, 0);

    // Same-index collision with the pointer at 0.
    vld[2] = 1'b1; cad[2] = AW'(1); cdt[2] = 32'h77;
    step(0, 0);
    vld[0] = 1'b1; cad[0] = AW'(9); cdt[0] = 32'hA;
    vld[1] = 1'b1; cad[1] = AW'(9); cdt[1] = 32'hB;
    step(0, 0);
    #1;
    chk("coll_first", 64'(rf_ry), 64'(32'hA));
    step(0, 0);
    #1;
    chk("coll_second", 64'(rf_ry), 64'(32'hB));
    step(0, 0);

    // Write to r0.
    vld[1] = 1'b1; cad[1] = '0; cdt[1] = 32'hFFFF;
    step(0, 0);
    #1;
    chk("r0_load_en", 64'(rf_load_enable), DROP ? 64'(0) : 64'(1));
    chk("r0_rc", 64'(rf_rc), 64'(0));
    step(0, 0);

    // Randomized traffic with random stalls.
    repeat (3000) step(1, $urandom_range(0, 3) == 0);
    clear_reqs();
    step(0, 0);
    step(0, 0);
    chk("sb_drain_pre", 64'(expq.size()), 64'(0));

    // Reset asserted with a write held in the stage.
    vld[0] = 1'b1; cad[0] = AW'(3); cdt[0] = 32'hCAFE;
    step(0, 0);
    @(negedge clk);
    in_rst = 1'b1;
    stall_tb = 1'b1;
    vld[1] = 1'b1; cad[1] = AW'(6); cdt[1] = 32'h66;
    drive();
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(req_ready), 64'(0));
    chk("mid_rst_load_en", 64'(rf_load_enable), 64'(0));
    chk("mid_rst_rc", 64'(rf_rc), 64'(0));
    chk("mid_rst_ry", 64'(rf_ry), 64'(0));
    chk("mid_rst_grant", 64'(grant_id), 64'(0));
    chk("mid_rst_pend", 64'(pend_mask), 64'(0));
    m_ov = 1'b0; m_ptr = 0; m_grant = 0;
    expq.delete();
    clear_reqs();
    stall_tb = 1'b0;
    drive();
    @(negedge clk);
    reset_n = 1'b1;
    in_rst  = 1'b0;
    repeat (4) step(0, 0);
    chk("sb_drain_post", 64'(expq.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Arbitrates register-file write traffic from several writeback sources (ALU result, load data, CSR/misc) onto the single write port of the 32x32 register file. It takes one valid/ready write request per cycle under round-robin priority, registers it in a one-entry output stage, and drives the file's `load_enable`, destination index and write data. A stall input holds the output stage, and a pending-address mask exposes the in-flight write to hazard logic.

## Interface
- `NREQ`, 2: number of requesters, legal 2..4.
- `AW`, 5: register index width.
- `DW`, 32: write data width.

- `clk` input 1: single clock; all state updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `req_valid` input NREQ: per-requester write request.
- `req_ready` output NREQ: per-requester accept, one-hot or zero.
- `req_addr` input NREQ*AW: destination index; requester i occupies bits [i*AW +: AW].
- `req_data` input NREQ*DW: write data; requester i occupies bits [i*DW +: DW].
- `rf_stall` input 1: hold the output stage and suppress the write.
- `rf_load_enable` output 1: write strobe to the register file.
- `rf_rc` output AW: destination index to the register file.
- `rf_ry` output DW: write data to the register file.
- `grant_id` output 2: index of the last accepted requester.
- `pend_mask` output 2**AW: one-hot index of the write held in the output stage; zero when the stage is empty.

## Operation
- **State:**
  - `out_valid` plus the output register holding addr and data.
  - `rr_ptr`: round-robin pointer, 0..NREQ-1.
- **Accept condition:** `can_take = !out_valid || !rf_stall`.
- **Arbitration:**
  - Search requesters starting at `rr_ptr`, in ascending order with wrap.
  - The first requester with `req_valid` high is the winner.
  - `req_ready[winner] = can_take`. All other ready bits are 0.
- **Handshake:**
  - A transfer occurs when `req_valid[i] && req_ready[i]`.
  - `req_ready` may depend combinationally on `req_valid`. Requesters must not make valid depend on ready.
  - Once asserted, valid, addr and data stay stable until the transfer completes.
- **On transfer:**
  - Load the output register with the winner's addr and data, and set `out_valid`.
  - `grant_id` takes the winner index.
  - `rr_ptr` becomes winner+1, wrapping mod NREQ.
- **No transfer and `!rf_stall`:** clear `out_valid`.
- **`rf_stall` high:** the output register, `out_valid`, `rr_ptr` and `grant_id` are all held.
- **Write outputs:**
  - `rf_load_enable = out_valid && !rf_stall`, qualified further as described under Configuration.
  - `rf_rc` and `rf_ry` are driven from the output register.
  - `pend_mask` has bit `rf_rc` set only while `out_valid` is high.
- **Same-index requests:** two requesters targeting the same index are serialized in grant order. The later grant wins in the register file.
- **Reset** (async assert, sync release):
  - `out_valid`, `rf_load_enable`, `rf_rc`, `rf_ry`, `grant_id`, `rr_ptr` and `pend_mask` all go to 0.
  - `req_ready` is 0 while `reset_n` is low.
  - A write in flight when reset asserts is discarded.

## Timing
- **Latency:** a request accepted at edge N appears as `rf_load_enable`/`rf_rc`/`rf_ry` during cycle N..N+1. The register file commits it at edge N+1.
- **Throughput:** one write per cycle when `rf_stall` is low, including back-to-back transfers from different requesters.
- **Stall:**
  - With the stage full and `rf_stall` high: `req_ready` is all 0 and `rf_load_enable` is 0.
  - The write issues in the first cycle `rf_stall` is low. A new request can be accepted in that same cycle.
- **Empty stage:** with the stage empty, `rf_stall` does not block acceptance.
- **Fairness:** with all requesters continuously valid, grants rotate 0,1,..,NREQ-1. Worst-case wait is NREQ-1 grants plus stall cycles.

## Configuration
- **`RF_WB_DROP_R0_EN` defined:**
  - Requests to index 0 handshake normally and occupy the output stage.
  - `rf_load_enable` is forced to 0 for them and `pend_mask` stays 0, so r0 reads as whatever the file holds (held at zero by policy).
- **Undefined:** index 0 is written like any other register.

## Test plan
- **Reset:** `reset_n` low mid-transfer with `out_valid` = 1 → all outputs 0 immediately. After release, no write issues until a new request arrives.
- **Single write:** req0 writes r5 = 0xDEADBEEF at edge N → `rf_load_enable` = 1, `rf_rc` = 5, `rf_ry` = 0xDEADBEEF in cycle N..N+1. `pend_mask` = 1<<5 in that cycle, then 0.
- **Round-robin:** NREQ = 3, all valid for 6 cycles → `grant_id` sequence 0,1,2,0,1,2. Exactly one `req_ready` high per cycle.
- **Stall:** stage holds r7 = 0x1234 with `rf_stall` high for 3 cycles → `rf_load_enable` = 0, `req_ready` = 0, data held. On stall release the write to r7 issues and req1's pending request is accepted in the same cycle.
- **Same-index collision:** req0 and req1 both target r9 with 0xA and 0xB, `rr_ptr` = 0 → r9 written 0xA, then 0xB on the following cycle.
- **r0 handling:** req1 writes r0 = 0xFFFF → with `RF_WB_DROP_R0_EN`, handshake completes but `rf_load_enable` stays 0. Without the macro, `rf_load_enable` = 1 and `rf_rc` = 0.
